// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer and its settle counter.
// Contents:
//   NUM_CH / SEL_W     channel count and select width of the 16x1 mux tree
//   CNT_W              width of the settle down-counter
//   MODE_SWEEP/SINGLE  encodings of the mode input
//   scan_state_t       sequencer states
//   settleLoad()       value loaded into the settle counter for one channel
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic MODE_SWEEP  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } scan_state_t;

  // The last settle cycle is spent in SAMPLE, so SETTLE itself only needs
  // SETTLE_CYCLES-1 extra counts; this keeps capture exactly
  // SETTLE_CYCLES+1 edges after sel changes with no gap between channels.
  function automatic logic [CNT_W-1:0] settleLoad(input int settleCycles);
    if (settleCycles == 0) begin
      return '0;
    end
    return CNT_W'(settleCycles - 1);
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that times the settle window for each channel.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_load       load i_loadVal (has priority over decrement)
//   i_loadVal    count to load
//   i_dec        decrement by one
//   o_zero       high while the count is zero
module settle_counter
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_loadVal,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_value;

  // Count register: a load restarts the window for a new channel, otherwise
  // the sequencer only decrements while the count is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_loadVal;
    end else if (i_dec) begin
      r_value <= r_value - CNT_W'(1);
    end
  end

  assign o_zero = (r_value == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives the select of a 16x1 mux tree and samples its output, either
// sweeping all channels or reading one, after a programmable settle time.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   i_start        scan request, only honoured while idle
//   i_mode         0 = sweep ch0..15, 1 = single channel
//   i_chan         channel for single mode, latched on acceptance
//   i_mux_out      output of the mux tree
//   o_sel          registered select to the mux tree
//   o_busy         scan in progress
//   o_done         one-cycle pulse when o_sampleVec updates
//   o_sampleVec    last completed results, bit k = channel k
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [SEL_W-1:0]  i_chan,
  input  logic              i_mux_out,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic [NUM_CH-1:0] o_sampleVec
);

  localparam logic [CNT_W-1:0] LOAD_VAL = settleLoad(SETTLE_CYCLES);

  // With no extra settle time every channel is sampled in the cycle right
  // after sel changes, so SETTLE is bypassed entirely.
  localparam scan_state_t FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  scan_state_t       r_state;
  scan_state_t       w_stateNext;
  logic [SEL_W-1:0]  r_sel;
  logic              r_busy;
  logic              r_done;
  logic              r_mode;
  logic [NUM_CH-1:0] r_sampleVec;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] w_shadowNext;
  logic              w_accept;
  logic              w_capture;
  logic              w_cntDec;
  logic              w_cntLoad;
  logic              w_cntZero;
  logic              w_moreChannels;

  assign w_moreChannels = (r_mode == MODE_SWEEP) && (r_sel != SEL_W'(NUM_CH - 1));
  assign w_cntLoad      = w_accept | (w_capture & w_moreChannels);

  settle_counter u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_cntLoad),
    .i_loadVal (LOAD_VAL),
    .i_dec     (w_cntDec),
    .o_zero    (w_cntZero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and strobes. SAMPLE is the final cycle of each channel's
  // window; its closing edge captures the mux output and either moves to
  // the next channel or finishes the scan.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cntDec    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_stateNext = FIRST_STATE;
        end
      end
      SETTLE: begin
        if (w_cntZero) begin
          w_stateNext = SAMPLE;
        end else begin
          w_cntDec = 1'b1;
        end
      end
      SAMPLE: begin
        w_capture   = 1'b1;
        w_stateNext = w_moreChannels ? FIRST_STATE : IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Shadow vector with the bit for the current channel replaced by the
  // live mux output; this is what gets stored on a capture edge.
  always_comb begin
    w_shadowNext        = r_shadow;
    w_shadowNext[r_sel] = i_mux_out;
  end

  // Datapath registers. The shadow is seeded from the published results so
  // a single-channel scan only changes its own bit; a sweep overwrites all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mode      <= MODE_SWEEP;
      r_sampleVec <= '0;
      r_shadow    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sel    <= (i_mode == MODE_SINGLE) ? i_chan : '0;
        r_mode   <= i_mode;
        r_busy   <= 1'b1;
        r_shadow <= r_sampleVec;
      end
      if (w_capture) begin
        r_shadow <= w_shadowNext;
        if (w_moreChannels) begin
          r_sel <= r_sel + SEL_W'(1);
        end else begin
          r_sampleVec <= w_shadowNext;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
      end
    end
  end

  assign o_sel       = r_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sampleVec = r_sampleVec;

endmodule
